// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller that steps an external 1-bit shifter |amount| times.
module shift_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcIn,
  input  logic [4:0]       amount,
  input  logic             shiftType,
  output logic [WIDTH-1:0] shSrc,
  output logic [WIDTH-1:0] shDir,
  output logic             shType,
  input  logic [WIDTH-1:0] shResult,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shdir;
  logic [4:0]       r_cnt;
  logic             r_dir;
  logic             r_typ;
  logic             r_busy;
  logic             r_done;
  logic [4:0]       w_mag;
  logic             w_accept;
  // -16 negates to 5'b10000, which the unsigned counter reads as 16
  assign w_mag    = amount[4] ? 5'(-amount) : amount;
  assign w_accept = start && (r_state != SHIFT);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_typ   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_shdir <= '0;
    end else if (w_accept) begin
      r_acc   <= srcIn;
      r_cnt   <= w_mag;
      r_dir   <= amount[4];
      r_typ   <= shiftType;
      r_state <= (w_mag == 5'd0) ? DONE : SHIFT;
      r_busy  <= (w_mag != 5'd0);
      r_done  <= (w_mag == 5'd0);
      r_shdir <= (w_mag == 5'd0) ? '0 : amount[4] ? '1 : WIDTH'(1);
    end else if (r_state == SHIFT) begin
      r_acc <= shResult;
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_shdir <= '0;
      end
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
  assign shSrc  = r_acc;
  assign shType = r_typ;
  assign shDir  = r_shdir;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_acc;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vector table plus hand-written multi-cycle sequences for shift_sequencer.
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, shiftType;
  logic [15:0] srcIn, shSrc, shDir, shResult, result;
  logic [4:0]  amount;
  logic        shType, busy, done;
  int          n_vec = 0;
  int          n_err = 0;

  shift_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .srcIn(srcIn), .amount(amount),
    .shiftType(shiftType), .shSrc(shSrc), .shDir(shDir), .shType(shType),
    .shResult(shResult), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // reference 1-bit shifter sitting downstream of the sequencer
  always_comb
    shResult = (shDir == 16'hFFFF) ? (shType ? {1'b0, shSrc[15:1]} : {shSrc[15], shSrc[15:1]}) :
               (shDir == 16'h0001) ? {shSrc[14:0], 1'b0} : shSrc;

  typedef struct {
    logic [15:0] src;
    int          amt;
    logic        typ;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] src, input int amt, input logic typ, input logic [15:0] exp);
    int lat, nbusy, nbad, mag;
    mag = (amt < 0) ? -amt : amt;
    srcIn = src; amount = 5'(amt); shiftType = typ; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; nbusy = 0; nbad = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (shDir !== ((amt < 0) ? 16'hFFFF : 16'h0001)) nbad++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, mag + 1);
    check("busy_cycles", nbusy, mag);
    check("shdir_in_shift", nbad, 0);
    check("result", {16'h0, result}, {16'h0, exp});
    check("busy_at_done", {31'h0, busy}, 0);
    check("shdir_at_done", {16'h0, shDir}, 0);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 0);
    check("result_hold", {16'h0, result}, {16'h0, exp});
  endtask

  initial begin
    vec_t vt[10];
    int   seen;
    vt[0] = '{16'h8001,   1, 1'b1, 16'h0002};
    vt[1] = '{16'h8000,  -3, 1'b0, 16'hF000};
    vt[2] = '{16'hFFFF, -16, 1'b1, 16'h0000};
    vt[3] = '{16'h1234,   0, 1'b0, 16'h1234};
    vt[4] = '{16'h8000, -16, 1'b0, 16'hFFFF};
    vt[5] = '{16'h0001,  15, 1'b1, 16'h8000};
    vt[6] = '{16'h00F0,  -4, 1'b1, 16'h000F};
    vt[7] = '{16'h8421,   4, 1'b0, 16'h4210};
    vt[8] = '{16'hF0F0,  -8, 1'b0, 16'hFFF0};
    vt[9] = '{16'h0003,   2, 1'b1, 16'h000C};

    reset = 1'b1; start = 1'b0; srcIn = 16'hA5A5; amount = 5'd3; shiftType = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_result", {16'h0, result}, 0);
    check("rst_shdir", {16'h0, shDir}, 0);
    check("rst_shtype", {31'h0, shType}, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_op(vt[i].src, vt[i].amt, vt[i].typ, vt[i].exp);

    // start ignored while busy, then held high into DONE for a back-to-back op
    srcIn = 16'h8000; amount = 5'(-3); shiftType = 1'b0; start = 1'b1;
    @(negedge clk);
    check("b2b_busy1", {31'h0, busy}, 1);
    srcIn = 16'h5555; amount = 5'd7; shiftType = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    srcIn = 16'h0003; amount = 5'd2; shiftType = 1'b1; start = 1'b1;
    @(negedge clk);
    check("b2b_done1", {31'h0, done}, 1);
    check("b2b_result1", {16'h0, result}, 32'hF000);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy2", {31'h0, busy}, 1);
    check("b2b_done_low", {31'h0, done}, 0);
    check("b2b_acc_loaded", {16'h0, shSrc}, 32'h0003);
    @(negedge clk);
    @(negedge clk);
    check("b2b_done2", {31'h0, done}, 1);
    check("b2b_result2", {16'h0, result}, 32'h000C);
    @(negedge clk);

    // reset during the second SHIFT cycle aborts with no done pulse
    srcIn = 16'h8000; amount = 5'(-5); shiftType = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_done", {31'h0, done}, 0);
    check("abort_result", {16'h0, result}, 0);
    check("abort_shdir", {16'h0, shDir}, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(16'h0001, 3, 1'b1, 16'h0008);

    // reset wins over a simultaneous start
    srcIn = 16'hFFFF; amount = 5'd0; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio_done", {31'h0, done}, 0);
    check("rst_prio_result", {16'h0, result}, 0);
    @(negedge clk);
    check("rst_prio_idle", {31'h0, done | busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
